// File: rtl/window_integrator_mc.sv
// window_integrator_mc
//   Per-channel sliding-window magnitude integrator used as an over-current /
//   over-drive interlock beside the DAC/ADC sample cores. Each channel rectifies
//   offset-binary samples, sums them into chunks of 2^chunk_log2 samples, and
//   keeps a running total over the last 2^DEPTH_LOG2 chunks. A channel trips
//   when its total exceeds threshold_average * window length.
//
//   Optional feature macro: WINDOW_INTEGRATOR_PEAK_EN adds peak_total_concat.
//
//   State | meaning
//   IDLE  | waiting for enable; config latched on exit
//   WAIT  | waiting for sample core ready
//   FILL  | integrating, window not yet full
//   RUN   | integrating, window full (window_valid)
//   OOB   | trip or illegal config; holds until rst
//   ERR   | flush overrun; holds until rst
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   enable                   start from IDLE / keep running
//   chunk_log2               log2 samples per chunk (1..MAX_CHUNK_LOG2)
//   threshold_average        per-sample magnitude limit
//   sample_core_done         releases WAIT
//   sample_tick              integrate held magnitude of every channel
//   value_in_concat          channel k at [SAMPLE_W*(k+1)-1 -: SAMPLE_W]
//   value_ready_concat       per-channel load strobe for the held value
//   setup_done               FILL or RUN
//   window_valid             RUN
//   over_threshold(_ch)      sticky trip flags
//   err_config               sticky illegal chunk_log2
//   err_flush_overrun        sticky chunk boundary while flush busy
//   peak_total_concat        (PEAK_EN) max total per channel since leaving IDLE
module window_integrator_mc #(
  parameter int CHANNELS       = 8,
  parameter int SAMPLE_W       = 16,
  parameter int DEPTH_LOG2     = 4,
  parameter int MAX_CHUNK_LOG2 = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [4:0]                   chunk_log2,
  input  logic [SAMPLE_W-2:0]          threshold_average,
  input  logic                         sample_core_done,
  input  logic                         sample_tick,
  input  logic [CHANNELS*SAMPLE_W-1:0] value_in_concat,
  input  logic [CHANNELS-1:0]          value_ready_concat,
  output logic                         setup_done,
  output logic                         window_valid,
  output logic                         over_threshold,
  output logic [CHANNELS-1:0]          over_threshold_ch,
  output logic                         err_config,
  output logic                         err_flush_overrun
`ifdef WINDOW_INTEGRATOR_PEAK_EN
  ,
  output logic [CHANNELS*(SAMPLE_W+MAX_CHUNK_LOG2+DEPTH_LOG2)-1:0] peak_total_concat
`endif
);

  localparam int CHUNK_DEPTH = 1 << DEPTH_LOG2;
  localparam int ACC_W  = SAMPLE_W + MAX_CHUNK_LOG2;
  localparam int TOT_W  = ACC_W + DEPTH_LOG2;
  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W  = MAX_CHUNK_LOG2;
  localparam int FILL_W = DEPTH_LOG2 + 1;
  localparam int AW     = CH_W + DEPTH_LOG2;

  localparam logic [SAMPLE_W-1:0] HALF    = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [4:0]          MAX_C   = 5'(MAX_CHUNK_LOG2);
  localparam logic [CH_W-1:0]     LAST_CH = CH_W'(CHANNELS - 1);
  localparam logic [FILL_W-1:0]   FULL    = FILL_W'(CHUNK_DEPTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_FILL = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_OOB  = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  logic [2:0]            state;
  logic [4:0]            chunk_q;
  logic [TOT_W-1:0]      limit_q;
  logic [CNT_W-1:0]      cnt;
  logic [DEPTH_LOG2-1:0] ptr;
  logic [FILL_W-1:0]     fill_cnt;
  logic [SAMPLE_W-1:0]   mag     [CHANNELS];
  logic [ACC_W-1:0]      acc     [CHANNELS];
  logic [ACC_W-1:0]      staging [CHANNELS];
  logic [TOT_W-1:0]      total   [CHANNELS];
  logic [ACC_W-1:0]      hist_mem [0:(1<<AW)-1];

  // flush pipeline: issue (read old) -> write/accumulate -> compare
  logic            busy, iss_active, wr_valid, cmp_valid;
  logic [CH_W-1:0] iss_idx, wr_ch, cmp_ch;
  logic [ACC_W-1:0] rd_old;

  logic             active, cfg_ok, boundary, overrun, trip_now, going_idle;
  logic [CNT_W:0]   cnt_last;
  logic [TOT_W-1:0] tot_next;

  function automatic logic [SAMPLE_W-1:0] rectify(input logic [SAMPLE_W-1:0] x);
    return x[SAMPLE_W-1] ? (x - HALF) : (HALF - x);
  endfunction

  always_comb begin
    active     = (state == S_FILL) || (state == S_RUN);
    cfg_ok     = (chunk_log2 != 5'd0) && (chunk_log2 <= MAX_C);
    cnt_last   = ((CNT_W+1)'(1) << chunk_q) - (CNT_W+1)'(1);
    boundary   = active && sample_tick && ({1'b0, cnt} == cnt_last);
    overrun    = boundary && busy;
    trip_now   = cmp_valid && (total[cmp_ch] > limit_q);
    going_idle = active && !enable && !overrun && !trip_now;
    tot_next   = total[wr_ch] + TOT_W'(staging[wr_ch]) - TOT_W'(rd_old);
  end

  assign setup_done   = active;
  assign window_valid = (state == S_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      chunk_q           <= '0;
      limit_q           <= '0;
      cnt               <= '0;
      ptr               <= '0;
      fill_cnt          <= '0;
      busy              <= 1'b0;
      iss_active        <= 1'b0;
      iss_idx           <= '0;
      wr_valid          <= 1'b0;
      wr_ch             <= '0;
      cmp_valid         <= 1'b0;
      cmp_ch            <= '0;
      over_threshold    <= 1'b0;
      over_threshold_ch <= '0;
      err_config        <= 1'b0;
      err_flush_overrun <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        mag[k]     <= '0;
        acc[k]     <= '0;
        staging[k] <= '0;
        total[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++)
        if (value_ready_concat[k])
          mag[k] <= rectify(value_in_concat[SAMPLE_W*(k+1)-1 -: SAMPLE_W]);

      case (state)
        S_IDLE:
          if (enable) begin
            if (cfg_ok) begin
              state   <= S_WAIT;
              chunk_q <= chunk_log2;
              limit_q <= TOT_W'(threshold_average) << (chunk_log2 + 5'(DEPTH_LOG2));
            end else begin
              state      <= S_OOB;
              err_config <= 1'b1;
            end
          end
        S_WAIT:
          if (sample_core_done) state <= S_FILL;
        S_FILL, S_RUN:
          if (overrun) begin
            state             <= S_ERR;
            err_flush_overrun <= 1'b1;
          end else if (trip_now)
            state <= S_OOB;
          else if (!enable)
            state <= S_IDLE;
          else if (state == S_FILL && fill_cnt == FULL)
            state <= S_RUN;
        default: ;
      endcase

      wr_valid <= iss_active;
      if (iss_active) begin
        wr_ch <= iss_idx;
        if (iss_idx == LAST_CH) iss_active <= 1'b0;
        else                    iss_idx    <= iss_idx + CH_W'(1);
      end

      cmp_valid <= wr_valid;
      if (wr_valid) begin
        total[wr_ch] <= tot_next;
        cmp_ch       <= wr_ch;
        if (wr_ch == LAST_CH) begin
          busy <= 1'b0;
          ptr  <= ptr + DEPTH_LOG2'(1);
          if (fill_cnt != FULL) fill_cnt <= fill_cnt + FILL_W'(1);
        end
      end

      // Trips keep landing even after leaving FILL/RUN so every channel of
      // the flush in flight gets its flag.
      if (trip_now) begin
        over_threshold            <= 1'b1;
        over_threshold_ch[cmp_ch] <= 1'b1;
      end

      if (active && sample_tick) begin
        if (boundary) begin
          cnt <= '0;
          for (int k = 0; k < CHANNELS; k++) acc[k] <= '0;
          // on overrun the flush in progress still owns staging
          if (!busy) begin
            for (int k = 0; k < CHANNELS; k++) staging[k] <= acc[k] + ACC_W'(mag[k]);
            busy       <= 1'b1;
            iss_active <= 1'b1;
            iss_idx    <= '0;
          end
        end else begin
          cnt <= cnt + CNT_W'(1);
          for (int k = 0; k < CHANNELS; k++) acc[k] <= acc[k] + ACC_W'(mag[k]);
        end
      end

      if (going_idle) begin
        cnt        <= '0;
        ptr        <= '0;
        fill_cnt   <= '0;
        busy       <= 1'b0;
        iss_active <= 1'b0;
        wr_valid   <= 1'b0;
        cmp_valid  <= 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
          acc[k]   <= '0;
          total[k] <= '0;
        end
      end
    end
  end

  // History buffer has no reset: entries are only trusted once the window has
  // filled, before that the read data is forced to zero.
  always_ff @(posedge clk) begin
    if (iss_active) rd_old <= (fill_cnt < FULL) ? '0 : hist_mem[{iss_idx, ptr}];
    if (wr_valid)   hist_mem[{wr_ch, ptr}] <= staging[wr_ch];
  end

`ifdef WINDOW_INTEGRATOR_PEAK_EN
  logic [TOT_W-1:0] peak [CHANNELS];

  always_ff @(posedge clk) begin
    if (rst || state == S_IDLE) begin
      for (int k = 0; k < CHANNELS; k++) peak[k] <= '0;
    end else if (active && wr_valid && tot_next > peak[wr_ch]) begin
      peak[wr_ch] <= tot_next;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_peak
    assign peak_total_concat[TOT_W*(g+1)-1 -: TOT_W] = peak[g];
  end
`endif

endmodule

// File: tb/tb_window_integrator_mc.sv
// Self-checking bench for window_integrator_mc (CHANNELS=4, DEPTH_LOG2=2).
// The reference model tracks chunk sums per channel in a small ring and
// derives window totals and trip flags with plain arithmetic.
module tb_window_integrator_mc;
  localparam int CH = 4;
  localparam int SW = 16;
  localparam int DL = 2;
  localparam int MC = 20;
  localparam int TW = SW + MC + DL;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic sample_core_done = 1'b0;
  logic sample_tick = 1'b0;
  logic [4:0] chunk_log2 = 5'd0;
  logic [SW-2:0] threshold_average = '0;
  logic [CH*SW-1:0] value_in_concat = '0;
  logic [CH-1:0] value_ready_concat = '0;
  logic setup_done, window_valid, over_threshold, err_config, err_flush_overrun;
  logic [CH-1:0] over_threshold_ch;
`ifdef WINDOW_INTEGRATOR_PEAK_EN
  logic [CH*TW-1:0] peak_total_concat;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cur_mag [CH];

  always #5 clk = ~clk;

  window_integrator_mc #(
    .CHANNELS(CH), .SAMPLE_W(SW), .DEPTH_LOG2(DL), .MAX_CHUNK_LOG2(MC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .chunk_log2(chunk_log2),
    .threshold_average(threshold_average),
    .sample_core_done(sample_core_done),
    .sample_tick(sample_tick),
    .value_in_concat(value_in_concat),
    .value_ready_concat(value_ready_concat),
    .setup_done(setup_done),
    .window_valid(window_valid),
    .over_threshold(over_threshold),
    .over_threshold_ch(over_threshold_ch),
    .err_config(err_config),
    .err_flush_overrun(err_flush_overrun)
`ifdef WINDOW_INTEGRATOR_PEAK_EN
    ,
    .peak_total_concat(peak_total_concat)
`endif
  );

  // offset-binary sample with magnitude m, random side of mid-scale
  function automatic logic [SW-1:0] enc(input int m);
    logic [SW-1:0] half;
    half = SW'(1) << (SW - 1);
    if (m == 0 || $urandom_range(0, 1) == 1) return half + SW'(m);
    return half - SW'(m);
  endfunction

  task automatic drive_vals();
    @(negedge clk);
    for (int k = 0; k < CH; k++) value_in_concat[SW*k +: SW] = enc(cur_mag[k]);
    value_ready_concat = '1;
    @(negedge clk);
    value_ready_concat = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; enable = 1'b0; sample_tick = 1'b0;
    sample_core_done = 1'b0; value_ready_concat = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // returns #1 after the edge that samples the tick
  task automatic tick_at();
    @(negedge clk);
    sample_tick = 1'b1;
    @(posedge clk);
    #1 sample_tick = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [4:0] c, input logic [SW-2:0] thr);
    do_reset();
    for (int k = 0; k < CH; k++) cur_mag[k] = 0;
    drive_vals();
    chunk_log2 = c;
    threshold_average = thr;
    @(negedge clk) enable = 1'b1;
    @(negedge clk) sample_core_done = 1'b1;
    @(negedge clk) sample_core_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (setup_done !== 1'b0) begin n_errors++; $display("FAIL reset_setup_done got %0b exp 0", setup_done); end
    n_checks++; if (window_valid !== 1'b0) begin n_errors++; $display("FAIL reset_window_valid got %0b exp 0", window_valid); end
    n_checks++; if (over_threshold !== 1'b0) begin n_errors++; $display("FAIL reset_over_threshold got %0b exp 0", over_threshold); end
    n_checks++; if (over_threshold_ch !== 4'b0) begin n_errors++; $display("FAIL reset_over_ch got %b exp 0000", over_threshold_ch); end
    n_checks++; if (err_config !== 1'b0) begin n_errors++; $display("FAIL reset_err_config got %0b exp 0", err_config); end
    n_checks++; if (err_flush_overrun !== 1'b0) begin n_errors++; $display("FAIL reset_err_overrun got %0b exp 0", err_flush_overrun); end
`ifdef WINDOW_INTEGRATOR_PEAK_EN
    n_checks++; if (peak_total_concat !== '0) begin n_errors++; $display("FAIL reset_peak got %0h exp 0", peak_total_concat); end
`endif
  endtask

  task automatic test_config();
    int bad [2];
    bad[0] = 0; bad[1] = 21;
    for (int i = 0; i < 2; i++) begin
      do_reset();
      chunk_log2 = 5'(bad[i]);
      @(negedge clk) enable = 1'b1;
      @(negedge clk);
      n_checks++; if (err_config !== 1'b1) begin n_errors++; $display("FAIL cfg_err chunk=%0d got %0b exp 1", bad[i], err_config); end
      sample_core_done = 1'b1;
      @(negedge clk) sample_core_done = 1'b0;
      @(negedge clk);
      n_checks++; if (setup_done !== 1'b0) begin n_errors++; $display("FAIL cfg_oob_hold chunk=%0d got %0b exp 0", bad[i], setup_done); end
    end
    start_run(5'd20, 15'd100);
    @(negedge clk);
    n_checks++; if (err_config !== 1'b0) begin n_errors++; $display("FAIL cfg_legal20_err got %0b exp 0", err_config); end
    n_checks++; if (setup_done !== 1'b1) begin n_errors++; $display("FAIL cfg_legal20_setup got %0b exp 1", setup_done); end
  endtask

  task automatic test_zero();
    start_run(5'd2, 15'd100);
    for (int t = 1; t <= 64; t++) begin
      tick_at();
      wait_cyc(7);
      if (t == 15) begin
        n_checks++; if (window_valid !== 1'b0) begin n_errors++; $display("FAIL zero_wv_early got %0b exp 0", window_valid); end
      end
      if (t == 16) begin
        n_checks++; if (window_valid !== 1'b1) begin n_errors++; $display("FAIL zero_wv_full got %0b exp 1", window_valid); end
      end
    end
    n_checks++; if (over_threshold_ch !== 4'b0) begin n_errors++; $display("FAIL zero_no_trip got %b exp 0000", over_threshold_ch); end
    n_checks++; if (window_valid !== 1'b1) begin n_errors++; $display("FAIL zero_wv_end got %0b exp 1", window_valid); end
  endtask

  task automatic test_trip_timing();
    start_run(5'd2, 15'd100);
    cur_mag[2] = 101;
    drive_vals();
    for (int t = 1; t <= 15; t++) begin
      tick_at();
      wait_cyc(7);
    end
    n_checks++; if (over_threshold !== 1'b0) begin n_errors++; $display("FAIL trip_pre got %0b exp 0", over_threshold); end
    tick_at();
    wait_cyc(4);
    n_checks++; if (over_threshold_ch !== 4'b0000) begin n_errors++; $display("FAIL trip_plus4 got %b exp 0000", over_threshold_ch); end
    wait_cyc(1);
    n_checks++; if (over_threshold_ch !== 4'b0100) begin n_errors++; $display("FAIL trip_plus5 got %b exp 0100", over_threshold_ch); end
    n_checks++; if (over_threshold !== 1'b1) begin n_errors++; $display("FAIL trip_any got %0b exp 1", over_threshold); end
    n_checks++; if (setup_done !== 1'b0) begin n_errors++; $display("FAIL trip_oob_state got %0b exp 0", setup_done); end
  endtask

  task automatic test_saturate();
    start_run(5'd2, 15'd100);
    cur_mag[0] = 100;
    drive_vals();
    for (int t = 1; t <= 32; t++) begin
      tick_at();
      wait_cyc(7);
    end
    n_checks++; if (over_threshold !== 1'b0) begin n_errors++; $display("FAIL sat_equal_no_trip got %0b exp 0", over_threshold); end
    n_checks++; if (window_valid !== 1'b1) begin n_errors++; $display("FAIL sat_wv got %0b exp 1", window_valid); end
    cur_mag[0] = 200;
    drive_vals();
    for (int t = 1; t <= 3; t++) begin
      tick_at();
      wait_cyc(7);
    end
    tick_at();
    wait_cyc(2);
    n_checks++; if (over_threshold_ch !== 4'b0000) begin n_errors++; $display("FAIL sat_plus2 got %b exp 0000", over_threshold_ch); end
    wait_cyc(1);
    n_checks++; if (over_threshold_ch !== 4'b0001) begin n_errors++; $display("FAIL sat_plus3 got %b exp 0001", over_threshold_ch); end
  endtask

  task automatic test_overrun();
    start_run(5'd1, 15'd100);
    @(negedge clk) sample_tick = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (err_flush_overrun !== 1'b0) begin n_errors++; $display("FAIL ovr_first_boundary got %0b exp 0", err_flush_overrun); end
    @(posedge clk);
    #1 sample_tick = 1'b0;
    n_checks++; if (err_flush_overrun !== 1'b1) begin n_errors++; $display("FAIL ovr_second_boundary got %0b exp 1", err_flush_overrun); end
    wait_cyc(3);
    n_checks++; if (setup_done !== 1'b0) begin n_errors++; $display("FAIL ovr_error_state got %0b exp 0", setup_done); end
  endtask

  task automatic test_random();
    int held [CH];
    int acc [CH];
    int win [CH][4];
    int newm [CH];
    int thr, lim, ntk, nch, tot, lo, hi;
    logic [CH-1:0] rdy, exp_ch;
    bit oob;
    for (int run = 0; run < 3; run++) begin
      thr = $urandom_range(90, 110);
      lim = thr * (1 << 2) * 4;
      start_run(5'd2, 15'(thr));
      for (int k = 0; k < CH; k++) begin
        held[k] = 0; acc[k] = 0;
        for (int j = 0; j < 4; j++) win[k][j] = 0;
      end
      ntk = 0; nch = 0; exp_ch = '0; oob = 1'b0;
      lo = 50 + run * 10; hi = 110 + run * 5;
      for (int t = 0; t < 48; t++) begin
        for (int k = 0; k < CH; k++) newm[k] = $urandom_range(lo, hi);
        rdy = 4'($urandom);
        @(negedge clk);
        for (int k = 0; k < CH; k++) value_in_concat[SW*k +: SW] = enc(newm[k]);
        value_ready_concat = rdy;
        sample_tick = 1'b1;
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
        value_ready_concat = '0;
        if (!oob) begin
          for (int k = 0; k < CH; k++) acc[k] += held[k];
          ntk++;
          if (ntk % 4 == 0) begin
            for (int k = 0; k < CH; k++) begin
              win[k][nch % 4] = acc[k];
              acc[k] = 0;
              tot = win[k][0] + win[k][1] + win[k][2] + win[k][3];
              if (tot > lim) exp_ch[k] = 1'b1;
            end
            nch++;
            if (exp_ch != '0) oob = 1'b1;
          end
        end
        for (int k = 0; k < CH; k++) if (rdy[k]) held[k] = newm[k];
        wait_cyc(7);
        n_checks++; if (over_threshold_ch !== exp_ch) begin n_errors++; $display("FAIL rnd_ch run=%0d t=%0d got %b exp %b", run, t, over_threshold_ch, exp_ch); end
        n_checks++; if (over_threshold !== (exp_ch != '0)) begin n_errors++; $display("FAIL rnd_any run=%0d t=%0d got %0b exp %0b", run, t, over_threshold, (exp_ch != '0)); end
        n_checks++; if (window_valid !== (!oob && nch >= 4)) begin n_errors++; $display("FAIL rnd_wv run=%0d t=%0d got %0b exp %0b", run, t, window_valid, (!oob && nch >= 4)); end
        n_checks++; if (setup_done !== !oob) begin n_errors++; $display("FAIL rnd_setup run=%0d t=%0d got %0b exp %0b", run, t, setup_done, !oob); end
      end
    end
  endtask

`ifdef WINDOW_INTEGRATOR_PEAK_EN
  task automatic test_peak();
    logic [TW-1:0] p0, p1;
    start_run(5'd2, 15'd1000);
    cur_mag[1] = 50;
    drive_vals();
    for (int t = 1; t <= 4; t++) begin
      tick_at();
      wait_cyc(7);
    end
    cur_mag[1] = 0;
    drive_vals();
    for (int t = 1; t <= 20; t++) begin
      tick_at();
      wait_cyc(7);
    end
    p0 = peak_total_concat[TW-1:0];
    p1 = peak_total_concat[2*TW-1 -: TW];
    n_checks++; if (p1 !== TW'(200)) begin n_errors++; $display("FAIL peak_ch1 got %0d exp 200", p1); end
    n_checks++; if (p0 !== TW'(0)) begin n_errors++; $display("FAIL peak_ch0 got %0d exp 0", p0); end
    @(negedge clk) enable = 1'b0;
    wait_cyc(3);
    n_checks++; if (peak_total_concat !== '0) begin n_errors++; $display("FAIL peak_idle_clear got %0h exp 0", peak_total_concat); end
  endtask
`endif

  initial begin
    for (int k = 0; k < CH; k++) cur_mag[k] = 0;
    test_reset();
    test_config();
    test_zero();
    test_trip_timing();
    test_saturate();
    test_overrun();
    test_random();
`ifdef WINDOW_INTEGRATOR_PEAK_EN
    test_peak();
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
